// File: rtl/instruction_fetch_pkg.sv
// rtl/instruction_fetch_pkg.sv - shared CPU constants for the fetch stage
package instruction_fetch_pkg;

  // Fetch FSM: fetching, or parked after a halt instruction retired
  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } fetch_state_t;

  localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;
  localparam int unsigned PC_INCREMENT      = 4;

endpackage

// File: rtl/program_counter.sv
// rtl/program_counter.sv - PC register with restart/branch/jump/sequential next-PC mux
module program_counter
  import instruction_fetch_pkg::*;
#(
  parameter int NB_ADDR = 12
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_restart,
  input  logic               i_branch,
  input  logic [NB_ADDR-1:0] i_branch_target,
  input  logic               i_jump,
  input  logic [NB_ADDR-1:0] i_jump_target,
  input  logic               i_advance,
  output logic [NB_ADDR-1:0] o_pc
);

  localparam logic [NB_ADDR-1:0] INC        = NB_ADDR'(PC_INCREMENT);
  localparam logic [NB_ADDR-1:0] ALIGN_MASK = ~NB_ADDR'(3);

  logic [NB_ADDR-1:0] pc_next;

  // Next-PC selection: restart beats redirects, branch beats jump, otherwise step or hold
  always_comb begin
    pc_next = o_pc;
    if (i_restart) begin
      pc_next = '0;
    end else if (i_branch) begin
      pc_next = i_branch_target & ALIGN_MASK;
    end else if (i_jump) begin
      pc_next = i_jump_target & ALIGN_MASK;
    end else if (i_advance) begin
      pc_next = o_pc + INC;
    end
  end

  // PC register, cleared asynchronously so the first fetch after reset is address 0
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_pc <= '0;
    end else begin
      o_pc <= pc_next;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - fetch stage: RUN/HALTED FSM, valid and pc+4 pipeline register
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int                   NB_DATA   = 32,
  parameter int                   NB_ADDR   = 12,
  parameter logic [NB_DATA-1:0]   HALT_WORD = NB_DATA'(HALT_WORD_DEFAULT)
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_instruction,
  input  logic               i_stall,
  input  logic               i_branch_taken,
  input  logic [NB_ADDR-1:0] i_branch_target,
  input  logic               i_jump,
  input  logic [NB_ADDR-1:0] i_jump_target,
  input  logic               i_restart,
  output logic [NB_ADDR-1:0] o_pc,
  output logic               o_mem_enable,
  output logic [NB_ADDR-1:0] o_pc_plus4,
  output logic               o_valid,
  output logic               o_halted
);

  localparam logic [NB_ADDR-1:0] INC = NB_ADDR'(PC_INCREMENT);

  fetch_state_t state;
  logic         running;
  logic         redirect;
  logic         halt_detect;

  // Redirects and halt detection only matter while fetching; a redirect squashes a halt
  always_comb begin
    running      = (state == ST_RUN);
    redirect     = running && (i_branch_taken || i_jump);
    halt_detect  = running && o_valid && (i_instruction == HALT_WORD) && !redirect;
    o_mem_enable = running && !i_stall;
    o_halted     = (state == ST_HALTED);
  end

  program_counter #(
    .NB_ADDR(NB_ADDR)
  ) u_program_counter (
    .i_clock        (i_clock),
    .i_reset        (i_reset),
    .i_restart      (o_halted && i_restart),
    .i_branch       (running && i_branch_taken),
    .i_branch_target(i_branch_target),
    .i_jump         (running && i_jump),
    .i_jump_target  (i_jump_target),
    .i_advance      (o_mem_enable && !halt_detect),
    .o_pc           (o_pc)
  );

  // FSM plus valid/pc_plus4 register; the fetch issued alongside a redirect or halt is dropped
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state      <= ST_RUN;
      o_valid    <= 1'b0;
      o_pc_plus4 <= '0;
    end else if (state == ST_RUN) begin
      if (redirect) begin
        o_valid <= 1'b0;
      end else if (halt_detect) begin
        state   <= ST_HALTED;
        o_valid <= 1'b0;
      end else if (o_mem_enable) begin
        o_pc_plus4 <= o_pc + INC;
        o_valid    <= 1'b1;
      end
    end else begin
      if (i_restart) begin
        state   <= ST_RUN;
        o_valid <= 1'b0;
      end
    end
  end

endmodule
